// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the miniRISC sequencer (master) and the fetch unit,
// ALU, data memory and PC logic it steers (slave).
interface alu_control_sequencer_if;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic        ALUzero;
    logic        MSB;
    logic        MemAck;
    logic        AddrSrcBSel;
    logic [1:0]  PrimaryOutputSel;
    logic        ShifterEnblALU;
    logic        ShifterInputSel;
    logic [1:0]  ShiftTypeALU;
    logic [4:0]  ShiftAmntALU;
    logic        ALUSrcImm;
    logic        RegWrite;
    logic        WBSrcMem;
    logic        MemRead;
    logic        MemWrite;
    logic        PCWrite;
    logic        NextPCSel;
    logic        IllegalInstr;

    modport master (
        input  Instr, InstrValid, ALUzero, MSB, MemAck,
        output InstrReady, AddrSrcBSel, PrimaryOutputSel, ShifterEnblALU,
               ShifterInputSel, ShiftTypeALU, ShiftAmntALU, ALUSrcImm,
               RegWrite, WBSrcMem, MemRead, MemWrite, PCWrite, NextPCSel,
               IllegalInstr
    );

    modport slave (
        output Instr, InstrValid, ALUzero, MSB, MemAck,
        input  InstrReady, AddrSrcBSel, PrimaryOutputSel, ShifterEnblALU,
               ShifterInputSel, ShiftTypeALU, ShiftAmntALU, ALUSrcImm,
               RegWrite, WBSrcMem, MemRead, MemWrite, PCWrite, NextPCSel,
               IllegalInstr
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for miniRISC: decodes one
// instruction per handshake and drives ALU controls and write strobes.
module alu_control_sequencer (
    input  logic                    clk,
    input  logic                    rst,
    alu_control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_LW,
        C_SW,
        C_BRANCH,
        C_ILLEGAL
    } class_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] shamt;
        logic [4:0] funct;
    } instr_t;

    typedef struct packed {
        logic [1:0] sel;
        logic       sub;
        logic       shift_en;
        logic [1:0] shift_type;
        logic [4:0] shift_amnt;
        logic       src_imm;
    } alu_ctrl_t;

    state_t    state;
    state_t    next_state;
    instr_t    instr_q;
    alu_ctrl_t ctrl_q;
    alu_ctrl_t dec_ctrl;
    class_t    dec_class;
    logic      accept;
    logic      taken;

    logic instr_ready;
    logic reg_write;
    logic wb_src_mem;
    logic mem_read;
    logic mem_write;
    logic pc_write;
    logic next_pc_sel;
    logic illegal_instr;

    // Register/immediate fields feed the datapath directly, not this block.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.Instr[25:11], bus.Instr[5]};

    assign accept = (state == S_FETCH) && bus.InstrValid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_FETCH;
            instr_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                instr_q <= {bus.Instr[31:26], bus.Instr[10:6], bus.Instr[4:0]};
            end
            if ((state == S_DECODE) && (next_state == S_EXEC)) begin
                ctrl_q <= dec_ctrl;
            end else if (next_state == S_FETCH) begin
                ctrl_q <= '0;
            end
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path through the block can leave a latch behind.
    always_comb begin
        dec_class = C_ILLEGAL;
        dec_ctrl  = '0;
        unique case (instr_q.opcode)
            6'd0: begin
                dec_class = C_ALU;
                unique case (instr_q.funct)
                    5'd0: dec_ctrl.sel = 2'd1;
                    5'd1: begin
                        dec_ctrl.sel = 2'd1;
                        dec_ctrl.sub = 1'b1;
                    end
                    5'd2: dec_ctrl.sel = 2'd3;
                    5'd3: dec_ctrl.sel = 2'd2;
                    5'd4: dec_ctrl.sel = 2'd0;
                    5'd5, 5'd6, 5'd7: begin
                        dec_ctrl.shift_en   = 1'b1;
                        dec_ctrl.shift_type = instr_q.funct[1:0] - 2'd1;
                        dec_ctrl.shift_amnt = instr_q.shamt;
                    end
                    default: dec_class = C_ILLEGAL;
                endcase
            end
            6'd1, 6'd2, 6'd3: begin
                dec_ctrl.sel     = 2'd1;
                dec_ctrl.src_imm = 1'b1;
                unique case (instr_q.opcode[1:0])
                    2'd2:    dec_class = C_LW;
                    2'd3:    dec_class = C_SW;
                    default: dec_class = C_ALU;
                endcase
            end
            6'd4, 6'd5, 6'd6, 6'd7: dec_class = C_BRANCH;
            default: dec_class = C_ILLEGAL;
        endcase
    end

    // Branch condition from the live flags; only consumed while in EXEC.
    always_comb begin
        taken = 1'b0;
        unique case (instr_q.opcode[1:0])
            2'd0: taken = bus.ALUzero;
            2'd1: taken = !bus.ALUzero;
            2'd2: taken = bus.MSB;
            2'd3: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state    = state;
        instr_ready   = 1'b0;
        reg_write     = 1'b0;
        wb_src_mem    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        pc_write      = 1'b0;
        next_pc_sel   = 1'b0;
        illegal_instr = 1'b0;
        unique case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (bus.InstrValid) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_class == C_ILLEGAL) begin
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                    next_state    = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (dec_class)
                    C_LW, C_SW: next_state = S_MEM;
                    C_BRANCH: begin
                        pc_write    = 1'b1;
                        next_pc_sel = taken;
                        next_state  = S_FETCH;
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                mem_read  = (dec_class == C_LW);
                mem_write = (dec_class == C_SW);
                if (bus.MemAck) begin
                    if (dec_class == C_LW) begin
                        next_state = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        next_state = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_src_mem = (dec_class == C_LW);
                pc_write   = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign bus.InstrReady       = instr_ready;
    assign bus.AddrSrcBSel      = ctrl_q.sub;
    assign bus.PrimaryOutputSel = ctrl_q.sel;
    assign bus.ShifterEnblALU   = ctrl_q.shift_en;
    assign bus.ShifterInputSel  = ctrl_q.shift_en;
    assign bus.ShiftTypeALU     = ctrl_q.shift_type;
    assign bus.ShiftAmntALU     = ctrl_q.shift_amnt;
    assign bus.ALUSrcImm        = ctrl_q.src_imm;
    assign bus.RegWrite         = reg_write;
    assign bus.WBSrcMem         = wb_src_mem;
    assign bus.MemRead          = mem_read;
    assign bus.MemWrite         = mem_write;
    assign bus.PCWrite          = pc_write;
    assign bus.NextPCSel        = next_pc_sel;
    assign bus.IllegalInstr     = illegal_instr;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: stimulus pushes the expected output
// vector of every cycle into a queue; a negedge monitor pops and compares.
module tb_alu_control_sequencer;

    typedef struct packed {
        logic       instr_ready;
        logic       bsel;
        logic [1:0] sel;
        logic       shen;
        logic       shin;
        logic [1:0] st;
        logic [4:0] sa;
        logic       imm;
        logic       rw;
        logic       wbm;
        logic       mr;
        logic       mw;
        logic       pcw;
        logic       npc;
        logic       ill;
    } out_t;

    typedef struct {
        logic [31:0] ins;
        out_t        alu;
        string       nm;
    } rvec_t;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic        m;
        logic        npc;
        string       nm;
    } bvec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    out_t exp_q[$];
    string name_q[$];
    out_t  mon_exp;
    string mon_nm;
    rvec_t rtab[9];
    bvec_t btab[7];
    logic [31:0] itab[3];

    alu_control_sequencer_if bus ();

    alu_control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic out_t f_fetch();
        out_t o = '0;
        o.instr_ready = 1'b1;
        return o;
    endfunction

    function automatic out_t f_alu(input logic [1:0] sel, input logic bsel, input logic shen,
                                   input logic [1:0] st, input logic [4:0] sa, input logic imm);
        out_t o = '0;
        o.sel  = sel;
        o.bsel = bsel;
        o.shen = shen;
        o.shin = shen;
        o.st   = st;
        o.sa   = sa;
        o.imm  = imm;
        return o;
    endfunction

    function automatic out_t f_wb(input out_t a, input logic wbm);
        out_t o = a;
        o.rw  = 1'b1;
        o.wbm = wbm;
        o.pcw = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.instr_ready = bus.InstrReady;
        o.bsel        = bus.AddrSrcBSel;
        o.sel         = bus.PrimaryOutputSel;
        o.shen        = bus.ShifterEnblALU;
        o.shin        = bus.ShifterInputSel;
        o.st          = bus.ShiftTypeALU;
        o.sa          = bus.ShiftAmntALU;
        o.imm         = bus.ALUSrcImm;
        o.rw          = bus.RegWrite;
        o.wbm         = bus.WBSrcMem;
        o.mr          = bus.MemRead;
        o.mw          = bus.MemWrite;
        o.pcw         = bus.PCWrite;
        o.npc         = bus.NextPCSel;
        o.ill         = bus.IllegalInstr;
        return o;
    endfunction

    // One clock cycle of stimulus plus the outputs expected during it.
    task automatic cyc(input logic r, input logic v, input logic [31:0] ins, input logic z,
                       input logic m, input logic ack, input out_t e, input string nm);
        rst            = r;
        bus.InstrValid = v;
        bus.Instr      = ins;
        bus.ALUzero    = z;
        bus.MSB        = m;
        bus.MemAck     = ack;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            check(mon_nm, sample(), mon_exp);
        end
    end

    out_t a_mem;
    out_t e;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.Instr = '0;
        bus.InstrValid = 1'b0;
        bus.ALUzero = 1'b0;
        bus.MSB = 1'b0;
        bus.MemAck = 1'b0;

        rtab[0] = '{32'h0043_2001, f_alu(2'd1, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0), "sub"};
        rtab[1] = '{32'h0000_0347, f_alu(2'd0, 1'b0, 1'b1, 2'd2, 5'd13, 1'b0), "shra13"};
        rtab[2] = '{32'h0000_0000, f_alu(2'd1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0), "add"};
        rtab[3] = '{32'h0000_0002, f_alu(2'd3, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0), "and"};
        rtab[4] = '{32'h0000_0003, f_alu(2'd2, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0), "xor"};
        rtab[5] = '{32'h0000_0004, f_alu(2'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0), "diff"};
        rtab[6] = '{32'h0000_0045, f_alu(2'd0, 1'b0, 1'b1, 2'd0, 5'd1, 1'b0), "shll1"};
        rtab[7] = '{32'h0000_07C6, f_alu(2'd0, 1'b0, 1'b1, 2'd1, 5'd31, 1'b0), "shrl31"};
        rtab[8] = '{32'h0400_1234, f_alu(2'd1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1), "addi"};

        btab[0] = '{32'h1000_0000, 1'b1, 1'b0, 1'b1, "bz_z1"};
        btab[1] = '{32'h1000_0000, 1'b0, 1'b1, 1'b0, "bz_z0"};
        btab[2] = '{32'h1400_0000, 1'b1, 1'b0, 1'b0, "bnz_z1"};
        btab[3] = '{32'h1400_0000, 1'b0, 1'b0, 1'b1, "bnz_z0"};
        btab[4] = '{32'h1800_0000, 1'b0, 1'b1, 1'b1, "bltz_m1"};
        btab[5] = '{32'h1800_0000, 1'b1, 1'b0, 1'b0, "bltz_m0"};
        btab[6] = '{32'h1C00_0000, 1'b0, 1'b0, 1'b1, "br"};

        itab[0] = 32'hFC00_0000;
        itab[1] = 32'h0000_0009;
        itab[2] = 32'h2000_0000;

        a_mem = f_alu(2'd1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1);

        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, f_fetch(), "reset_fetch");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, f_fetch(), "idle_hold0");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, f_fetch(), "idle_hold1");

        // Register/immediate ALU ops: FETCH, DECODE, EXEC, WB; junk on ignored inputs.
        foreach (rtab[i]) begin
            cyc(1'b1, 1'b1, rtab[i].ins, 1'b0, 1'b0, 1'b0, f_fetch(), {rtab[i].nm, "_accept"});
            cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, '0, {rtab[i].nm, "_decode"});
            cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, rtab[i].alu, {rtab[i].nm, "_exec"});
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, f_wb(rtab[i].alu, 1'b0), {rtab[i].nm, "_wb"});
        end

        // lw with three MEM wait cycles: 8 cycles total.
        cyc(1'b1, 1'b1, 32'h0800_0010, 1'b0, 1'b0, 1'b0, f_fetch(), "lw_accept");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, "lw_decode");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a_mem, "lw_exec");
        e = a_mem;
        e.mr = 1'b1;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, "lw_mem_wait0");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, "lw_mem_wait1");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, "lw_mem_wait2");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e, "lw_mem_ack");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, f_wb(a_mem, 1'b1), "lw_wb");

        // sw with immediate ack: PCWrite in MEM, 4 cycles total.
        cyc(1'b1, 1'b1, 32'h0C00_0004, 1'b0, 1'b0, 1'b0, f_fetch(), "sw_accept");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, "sw_decode");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, a_mem, "sw_exec");
        e = a_mem;
        e.mw  = 1'b1;
        e.pcw = 1'b1;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e, "sw_mem_ack");

        // Branches: opposite flags in DECODE and after EXEC must not matter.
        foreach (btab[i]) begin
            cyc(1'b1, 1'b1, btab[i].ins, 1'b0, 1'b0, 1'b0, f_fetch(), {btab[i].nm, "_accept"});
            cyc(1'b1, 1'b0, 32'h0, !btab[i].z, !btab[i].m, 1'b0, '0, {btab[i].nm, "_decode"});
            e = '0;
            e.pcw = 1'b1;
            e.npc = btab[i].npc;
            cyc(1'b1, 1'b0, 32'h0, btab[i].z, btab[i].m, 1'b0, e, {btab[i].nm, "_exec"});
        end

        // Illegal instructions: IllegalInstr + PCWrite in DECODE, 2 cycles total.
        foreach (itab[i]) begin
            cyc(1'b1, 1'b1, itab[i], 1'b0, 1'b0, 1'b0, f_fetch(), $sformatf("illegal%0d_accept", i));
            e = '0;
            e.ill = 1'b1;
            e.pcw = 1'b1;
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e, $sformatf("illegal%0d_decode", i));
        end

        // Reset held for 2 cycles while lw waits in MEM.
        cyc(1'b1, 1'b1, 32'h0800_0020, 1'b0, 1'b0, 1'b0, f_fetch(), "rlw_accept");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, "rlw_decode");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, a_mem, "rlw_exec");
        e = a_mem;
        e.mr = 1'b1;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, "rlw_mem_wait");
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, e, "rlw_mem_reset_edge");
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, f_fetch(), "rlw_after_reset");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, f_fetch(), "rlw_released");

        // Normal operation resumes after reset.
        cyc(1'b1, 1'b1, rtab[0].ins, 1'b0, 1'b0, 1'b0, f_fetch(), "post_sub_accept");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, "post_sub_decode");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rtab[0].alu, "post_sub_exec");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, f_wb(rtab[0].alu, 1'b0), "post_sub_wb");
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, f_fetch(), "final_fetch");

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
